servo_ramp_controller: RTL and testbench
========================================

SERVO_RAMP_CONTROLLER -- requirements
Module: servo_ramp_controller

Interface
REQ-001 Parameter NCH, default 6: number of servo channels.
REQ-002 Parameter MAX_DUTY, default 99: largest legal duty value.
REQ-003 Parameter STEP, default 1: largest duty change per channel per tick in auto mode.
REQ-004 clock  input  1  system clock; every register updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tick  input  1  single-cycle update strobe from the slow clock generator, 20 Hz rate.
REQ-007 js_up  input  1  joystick increment request; level-sampled.
REQ-008 js_down  input  1  joystick decrement request; level-sampled.
REQ-009 js_sel  input  3  channel addressed by the joystick.
REQ-010 cfg_we  input  1  write strobe for the CPU configuration port.
REQ-011 cfg_ch  input  3  channel addressed by the CPU write.
REQ-012 cfg_target  input  7  target duty value.
REQ-013 cfg_manual  input  1  channel mode: 1 = joystick (manual), 0 = ramp to target (auto).
REQ-014 duty_out  output  7*NCH  registered duty values; channel i occupies bits [7i+6:7i]; feeds the PWM serializers.
REQ-015 at_target  output  NCH  bit i = 1 when channel i duty equals its target.
REQ-016 busy  output  1  high while the scan state machine is not IDLE.

Function
REQ-017 FSM states: IDLE and SCAN. IDLE -> SCAN on tick or on a pending tick; SCAN visits channel 0..NCH-1, one channel per cycle; SCAN -> IDLE after channel NCH-1.
REQ-018 A scan takes exactly NCH cycles. Channel i duty_out changes on the clock edge that ends scan cycle i.
REQ-019 A tick arriving while in SCAN sets a single pending flag. Further ticks during the same scan are dropped. The pending tick starts a new scan in the cycle after the scan returns to IDLE.
REQ-020 Manual channel, when it is scanned and equals js_sel:
  - js_up only: increment duty, saturating at MAX_DUTY.
  - js_down only: decrement duty, saturating at 0.
  - both or neither asserted: no change.
REQ-021 Manual channels not equal to js_sel hold their duty.
REQ-022 Auto channel: move duty toward the target by min(STEP, |target-duty|). Duty never overshoots the target.
REQ-023 cfg_we writes the target and mode registers of cfg_ch in any cycle, including during SCAN.
  - cfg_target values above MAX_DUTY are stored as MAX_DUTY.
  - cfg_ch >= NCH: the write is ignored.
REQ-024 A cfg write to the channel being scanned in the same cycle does not affect that cycle's update; the new value is used from the next scan.
REQ-025 Switching a channel from manual to auto ramps it from its current duty; switching from auto to manual holds its current duty.
REQ-026 at_target is combinational from the registered duty and target, and is valid in every state.
REQ-027 Duty arithmetic uses 8-bit intermediates, so the stored value never wraps past 0 or 127.

Reset
REQ-028 While reset is asserted, on the clock edge:
  - all duty_out = 0, all targets = 0, all modes = manual;
  - FSM = IDLE, pending flag = 0, busy = 0.
  After reset, at_target = all ones.
REQ-029 Reset asserted mid-scan aborts the scan; no partial update survives the reset.

Structure
REQ-030 A shared package servo_pkg holds the following, and the PWM serializer wrappers reuse it:
  - NCH, MAX_DUTY, the duty width (7);
  - the FSM state enumeration.
REQ-031 One sub-module, servo_step_unit: combinational next-duty calculation from (duty, target, manual, up, down, selected). It is instantiated once and time-shared by the scan.

Verification
REQ-032 Reset, then tick with all channels manual and no joystick input -> duty_out all 0, at_target all ones, busy high for exactly 6 cycles.
REQ-033 Manual path:
  - js_sel=2, js_up held, 5 ticks -> channel 2 duty = 5, all other channels = 0.
  - Hold js_up with duty at 99, then tick -> duty stays 99.
REQ-034 Auto ramp with STEP=4:
  - cfg ch 1 auto, target 10, 3 ticks -> duty 4, 8, 10; at_target[1] rises after the third scan.
  - Then target 0 -> duty 6, 2, 0.
REQ-035 cfg_target=120 on channel 0 in auto -> stored target 99; the ramp stops at 99.
REQ-036 Two ticks 2 cycles apart -> second scan starts the cycle after the first ends (12 busy cycles, one drop-free pending); a third tick within the same scan is dropped.
REQ-037 Reset asserted at scan cycle 3 with non-zero duties -> next cycle duty_out all 0, busy 0; the next tick starts a normal scan.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared servo constants and scan FSM state encoding.
// Also reused by the PWM serializer wrappers.
package servo_pkg;

    localparam int NCH      = 6;
    localparam int MAX_DUTY = 99;
    localparam int DUTY_W   = 7;
    localparam int CH_W     = 3;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

endpackage

// File: rtl/servo_step_unit.sv
// Next-duty calculation for one channel.
// Time-shared by the scan; 8-bit math keeps duty from wrapping.
module servo_step_unit #(
    parameter int MAX_DUTY = servo_pkg::MAX_DUTY,
    parameter int STEP     = 1
) (
    input  logic [servo_pkg::DUTY_W-1:0] duty,
    input  logic [servo_pkg::DUTY_W-1:0] target,
    input  logic                         manual,
    input  logic                         up,
    input  logic                         down,
    input  logic                         selected,
    output logic [servo_pkg::DUTY_W-1:0] next_duty
);
    import servo_pkg::*;

    logic [7:0] d8;
    logic [7:0] t8;
    logic [7:0] inc8;
    logic [7:0] diff8;
    logic [7:0] amt8;
    logic [7:0] max8;

    always_comb begin
        d8    = {1'b0, duty};
        t8    = {1'b0, target};
        max8  = 8'(MAX_DUTY);
        inc8  = d8 + 8'd1;
        diff8 = (t8 > d8) ? (t8 - d8) : (d8 - t8);
        // Clamp the step so the ramp lands exactly on the target.
        amt8  = (diff8 < 8'(STEP)) ? diff8 : 8'(STEP);
        next_duty = duty;
        unique case (1'b1)
            manual && selected && up && !down:
                next_duty = (inc8 > max8) ? DUTY_W'(max8) : DUTY_W'(inc8);
            manual && selected && down && !up:
                next_duty = (d8 == 8'd0) ? '0 : DUTY_W'(d8 - 8'd1);
            !manual && (t8 > d8):
                next_duty = DUTY_W'(d8 + amt8);
            !manual && (t8 < d8):
                next_duty = DUTY_W'(d8 - amt8);
            default:
                next_duty = duty;
        endcase
    end

endmodule

// File: rtl/servo_ramp_controller.sv
// Multi-channel servo duty controller: one channel updated per cycle
// per tick-triggered scan, in joystick or ramp-to-target mode.
module servo_ramp_controller #(
    parameter int NCH      = servo_pkg::NCH,
    parameter int MAX_DUTY = servo_pkg::MAX_DUTY,
    parameter int STEP     = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               js_up,
    input  logic               js_down,
    input  logic [2:0]         js_sel,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_ch,
    input  logic [6:0]         cfg_target,
    input  logic               cfg_manual,
    output logic [7*NCH-1:0]   duty_out,
    output logic [NCH-1:0]     at_target,
    output logic               busy
);
    import servo_pkg::*;

    state_t            state_q;
    state_t            state_d;
    logic              pending_q;
    logic              pending_d;
    logic [CH_W-1:0]   idx_q;
    logic [CH_W-1:0]   idx_d;
    logic [DUTY_W-1:0] duty_q   [NCH];
    logic [DUTY_W-1:0] target_q [NCH];
    logic [NCH-1:0]    manual_q;
    logic [DUTY_W-1:0] next_duty;
    logic [DUTY_W-1:0] cfg_clamped;

    servo_step_unit #(
        .MAX_DUTY (MAX_DUTY),
        .STEP     (STEP)
    ) u_step (
        .duty      (duty_q[idx_q]),
        .target    (target_q[idx_q]),
        .manual    (manual_q[idx_q]),
        .up        (js_up),
        .down      (js_down),
        .selected  (js_sel == idx_q),
        .next_duty (next_duty)
    );

    assign cfg_clamped = (cfg_target > DUTY_W'(MAX_DUTY))
                       ? DUTY_W'(MAX_DUTY) : cfg_target;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        unique case (state_q)
            IDLE: begin
                if (tick || pending_q) begin
                    state_d   = SCAN;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            SCAN: begin
                if (tick) pending_d = 1'b1;
                if (int'(idx_q) == NCH - 1) state_d = IDLE;
                else                        idx_d   = idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            idx_q     <= '0;
            manual_q  <= '1;
            for (int i = 0; i < NCH; i++) begin
                duty_q[i]   <= '0;
                target_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            if (state_q == SCAN) duty_q[idx_q] <= next_duty;
            if (cfg_we && int'(cfg_ch) < NCH) begin
                target_q[cfg_ch] <= cfg_clamped;
                manual_q[cfg_ch] <= cfg_manual;
            end
        end
    end

    always_comb begin
        duty_out  = '0;
        at_target = '0;
        for (int i = 0; i < NCH; i++) begin
            duty_out[7*i +: 7] = duty_q[i];
            at_target[i]       = (duty_q[i] == target_q[i]);
        end
    end

    assign busy = (state_q == SCAN);

endmodule

// File: tb/tb_servo_ramp_controller.sv
// Directed bench for servo_ramp_controller with a queue scoreboard.
module tb_servo_ramp_controller;

    localparam int NCH = 6;

    logic           clock = 1'b0;
    logic           reset;
    logic           tick;
    logic           js_up;
    logic           js_down;
    logic [2:0]     js_sel;
    logic           cfg_we;
    logic [2:0]     cfg_ch;
    logic [6:0]     cfg_target;
    logic           cfg_manual;
    logic [7*NCH-1:0] duty_out;
    logic [NCH-1:0] at_target;
    logic           busy;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    servo_ramp_controller #(
        .NCH      (NCH),
        .MAX_DUTY (99),
        .STEP     (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .js_up      (js_up),
        .js_down    (js_down),
        .js_sel     (js_sel),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_target (cfg_target),
        .cfg_manual (cfg_manual),
        .duty_out   (duty_out),
        .at_target  (at_target),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [63:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty observed=%0h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic run_tick(output int n);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            cyc();
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL tick_timeout observed=busy stuck expected=idle");
        end
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [6:0] tgt,
                             input logic man);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_target = tgt;
        cfg_manual = man;
        cyc();
        cfg_we     = 1'b0;
    endtask

    function automatic logic [6:0] ch_duty(input int ch);
        return duty_out[7*ch +: 7];
    endfunction

    initial begin
        int          n;
        logic [31:0] trace;
        reset = 1'b1; tick = 1'b0; js_up = 1'b0; js_down = 1'b0;
        js_sel = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_target = '0; cfg_manual = 1'b0;
        cyc(); cyc();
        reset = 1'b0;

        expect_v("rst_duty", 0);          check(64'(duty_out));
        expect_v("rst_at_target", 6'h3F); check(64'(at_target));
        expect_v("rst_busy", 0);          check(64'(busy));

        run_tick(n);
        expect_v("idle_scan_busy_cycles", 6); check(64'(n));
        expect_v("idle_scan_duty", 0);        check(64'(duty_out));
        expect_v("idle_scan_at", 6'h3F);      check(64'(at_target));

        js_sel = 3'd2; js_up = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            run_tick(n);
            expect_v($sformatf("manual_up_%0d", i), 64'(i));
            check(64'(ch_duty(2)));
        end
        expect_v("manual_others_zero", 64'(5) << 14);
        check(64'(duty_out));

        for (int i = 0; i < 95; i++) run_tick(n);
        expect_v("manual_saturate", 99); check(64'(ch_duty(2)));
        js_up = 1'b0;

        cfg_write(3'd1, 7'd10, 1'b0);
        expect_v("auto_start_at", 0); check(64'(at_target[1]));
        for (int i = 0; i < 3; i++) begin
            run_tick(n);
            expect_v($sformatf("ramp_up_%0d", i),
                     (i == 2) ? 64'd10 : 64'(4 * (i + 1)));
            check(64'(ch_duty(1)));
            expect_v($sformatf("ramp_up_at_%0d", i), (i == 2) ? 1 : 0);
            check(64'(at_target[1]));
        end
        cfg_write(3'd1, 7'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_tick(n);
            expect_v($sformatf("ramp_down_%0d", i),
                     (i == 2) ? 64'd0 : 64'(6 - 4 * i));
            check(64'(ch_duty(1)));
        end

        cfg_write(3'd0, 7'd120, 1'b0);
        for (int i = 0; i < 24; i++) run_tick(n);
        expect_v("clamp_ramp_96", 96); check(64'(ch_duty(0)));
        expect_v("clamp_at_96", 0);    check(64'(at_target[0]));
        for (int i = 0; i < 6; i++) run_tick(n);
        expect_v("clamp_stop_99", 99); check(64'(ch_duty(0)));
        expect_v("clamp_at_99", 1);    check(64'(at_target[0]));
        expect_v("manual_hold_ch2", 99); check(64'(ch_duty(2)));

        trace = '0;
        tick = 1'b1; cyc(); trace[0] = busy;
        tick = 1'b0; cyc(); trace[1] = busy;
        tick = 1'b1; cyc(); trace[2] = busy;
        tick = 1'b0; cyc(); trace[3] = busy;
        tick = 1'b1; cyc(); trace[4] = busy;
        tick = 1'b0;
        for (int i = 5; i < 30; i++) begin
            cyc();
            trace[i] = busy;
        end
        expect_v("pending_trace", 32'h0000_1FBF); check(64'(trace));
        expect_v("pending_busy_total", 12);      check(64'($countones(trace)));

        tick = 1'b1; cyc(); tick = 1'b0;
        cyc(); cyc(); cyc();
        expect_v("pre_reset_ch0", 99); check(64'(ch_duty(0)));
        reset = 1'b1; cyc(); reset = 1'b0;
        expect_v("midscan_rst_duty", 0);   check(64'(duty_out));
        expect_v("midscan_rst_busy", 0);   check(64'(busy));
        expect_v("midscan_rst_at", 6'h3F); check(64'(at_target));

        cfg_write(3'd6, 7'd50, 1'b0);
        cfg_write(3'd7, 7'd50, 1'b0);
        expect_v("cfg_out_of_range", 6'h3F); check(64'(at_target));

        js_sel = 3'd2; js_up = 1'b1;
        run_tick(n);
        js_up = 1'b0;
        expect_v("post_rst_busy", 6);           check(64'(n));
        expect_v("post_rst_duty", 64'(1) << 14); check(64'(duty_out));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
